// File: rtl/rsp_s2_dma_ahbic_in_stage_if.sv
// AHB input-stage bus bundle: master-side address/response and decoder-side address/response.
// Latency: none, wires only.
// Backpressure: carries HREADYS/HREADYOUTS and the decoder's readyout_in/active_in grant.
interface rsp_s2_dma_ahbic_in_stage_if;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic        HREADYS;
    logic        HREADYOUTS;
    logic [1:0]  HRESPS;

    logic        active_in;
    logic        readyout_in;
    logic [1:0]  resp_in;
    logic        sel_in;
    logic [31:0] addr_in;
    logic [1:0]  trans_in;
    logic        write_in;
    logic [2:0]  size_in;
    logic [2:0]  burst_in;
    logic [3:0]  prot_in;
    logic        ready_in;

    modport slave (
        input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HREADYS,
        input  active_in, readyout_in, resp_in,
        output sel_in, addr_in, trans_in, write_in, size_in, burst_in, prot_in, ready_in,
        output HREADYOUTS, HRESPS
    );

    modport master (
        output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HREADYS,
        output active_in, readyout_in, resp_in,
        input  sel_in, addr_in, trans_in, write_in, size_in, burst_in, prot_in, ready_in,
        input  HREADYOUTS, HRESPS
    );
endinterface

// File: rtl/rsp_s2_dma_ahbic_in_stage.sv
// AHB interconnect input stage: holds an address phase until the decoder grants this port.
// Latency: zero when granted in the address cycle, else N+1 wait states (N = cycles without grant).
// Backpressure: HREADYOUTS held low while pending; RSP_S2_DMA_AHBIC_HOLD_CNT_EN adds the hold counter.
module rsp_s2_dma_ahbic_in_stage #(
    parameter int HOLD_CNT_W = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    rsp_s2_dma_ahbic_in_stage_if.slave bus,
    output logic [HOLD_CNT_W-1:0] hold_cnt
);

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
    } hdr_t;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   data_valid_q, data_valid_d;
    hdr_t   hold_q, live_hdr, out_hdr;
    logic   valid_new, capture;
    logic   out_sel, out_ready, out_readyout;
    logic [1:0] out_resp;

    // NONSEQ and SEQ both have HTRANS[1] set; IDLE/BUSY never qualify.
    assign valid_new = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS;
    assign live_hdr  = {bus.HADDRS, bus.HTRANSS, bus.HWRITES, bus.HSIZES, bus.HBURSTS, bus.HPROTS};

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q      <= IDLE;
            data_valid_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            data_valid_q <= data_valid_d;
            if (capture) hold_q <= live_hdr;
        end
    end

    always_comb begin
        state_d      = state_q;
        data_valid_d = data_valid_q;
        capture      = 1'b0;
        out_sel      = bus.HSELS;
        out_hdr      = live_hdr;
        out_ready    = bus.HREADYS;
        out_readyout = data_valid_q ? bus.readyout_in : 1'b1;
        out_resp     = data_valid_q ? bus.resp_in : 2'b00;
        case (state_q)
            IDLE: begin
                if (valid_new && !bus.active_in) begin
                    state_d      = PEND;
                    capture      = 1'b1;
                    data_valid_d = 1'b0;
                end else if (valid_new) begin
                    data_valid_d = 1'b1;
                end else if (bus.readyout_in) begin
                    data_valid_d = 1'b0;
                end
            end
            PEND: begin
                // Master inputs are ignored here; only the grant moves us on.
                out_sel      = 1'b1;
                out_hdr      = hold_q;
                out_ready    = 1'b1;
                out_readyout = 1'b0;
                out_resp     = 2'b00;
                if (bus.active_in) begin
                    state_d      = IDLE;
                    data_valid_d = 1'b1;
                end
            end
        endcase
    end

    assign bus.sel_in     = out_sel;
    assign bus.addr_in    = out_hdr.addr;
    assign bus.trans_in   = out_hdr.trans;
    assign bus.write_in   = out_hdr.write;
    assign bus.size_in    = out_hdr.size;
    assign bus.burst_in   = out_hdr.burst;
    assign bus.prot_in    = out_hdr.prot;
    assign bus.ready_in   = out_ready;
    assign bus.HREADYOUTS = out_readyout;
    assign bus.HRESPS     = out_resp;

`ifdef RSP_S2_DMA_AHBIC_HOLD_CNT_EN
    logic [HOLD_CNT_W-1:0] cnt_q;

    // Counts ungranted PEND cycles, so the grant cycle itself is not included.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            cnt_q <= '0;
        end else if (capture) begin
            cnt_q <= '0;
        end else if (state_q == PEND && !bus.active_in && cnt_q != {HOLD_CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + {{(HOLD_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign hold_cnt = cnt_q;
`else
    assign hold_cnt = '0;
`endif

endmodule

// File: tb/tb_rsp_s2_dma_ahbic_in_stage.sv
// Directed bench for the AHB input stage: pass-through, held transfers, bursts, ERROR, reset, counter.
module tb_rsp_s2_dma_ahbic_in_stage;

`ifdef RSP_S2_DMA_AHBIC_HOLD_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic [7:0] hold_cnt;
    int         n_chk  = 0;
    int         n_fail = 0;

    rsp_s2_dma_ahbic_in_stage_if bus ();

    rsp_s2_dma_ahbic_in_stage #(.HOLD_CNT_W(8)) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .bus      (bus.slave),
        .hold_cnt (hold_cnt)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic master(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                          input logic write, input logic rdy);
        bus.HSELS   = sel;
        bus.HADDRS  = addr;
        bus.HTRANSS = trans;
        bus.HWRITES = write;
        bus.HSIZES  = 3'd2;
        bus.HBURSTS = 3'd1;
        bus.HPROTS  = 4'd3;
        bus.HREADYS = rdy;
    endtask

    task automatic decoder(input logic act, input logic rdy, input logic [1:0] resp);
        bus.active_in   = act;
        bus.readyout_in = rdy;
        bus.resp_in     = resp;
    endtask

    initial begin
        HRESET = 1'b1;
        master(1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
        decoder(1'b1, 1'b1, 2'b00);
        tick();
        tick();
        HRESET = 1'b0;
        #1;
        chk("rst_readyout", 64'(bus.HREADYOUTS), 64'd1);
        chk("rst_resp", 64'(bus.HRESPS), 64'd0);
        chk("rst_sel", 64'(bus.sel_in), 64'd0);
        chk("rst_ready_in", 64'(bus.ready_in), 64'd1);
        chk("rst_hold_cnt", 64'(hold_cnt), 64'd0);
        chk("rst_hold_reg", {19'b0, dut.hold_q}, 64'd0);

        // Zero-wait NONSEQ write to 0x400.
        tick();
        master(1'b1, 32'h400, 2'b10, 1'b1, 1'b1);
        decoder(1'b1, 1'b1, 2'b00);
        #1;
        chk("zw_sel", 64'(bus.sel_in), 64'd1);
        chk("zw_addr", 64'(bus.addr_in), 64'h400);
        chk("zw_trans", 64'(bus.trans_in), 64'd2);
        chk("zw_write", 64'(bus.write_in), 64'd1);
        chk("zw_readyout_a", 64'(bus.HREADYOUTS), 64'd1);
        tick();
        master(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
        decoder(1'b1, 1'b0, 2'b00);
        #1;
        chk("zw_data_wait", 64'(bus.HREADYOUTS), 64'd0);
        chk("zw_still_idle", 64'(bus.sel_in), 64'd0);
        tick();
        decoder(1'b1, 1'b1, 2'b00);
        bus.HREADYS = 1'b1;
        #1;
        chk("zw_data_done", 64'(bus.HREADYOUTS), 64'd1);
        tick();
        decoder(1'b1, 1'b0, 2'b00);
        #1;
        chk("zw_dv_cleared", 64'(bus.HREADYOUTS), 64'd1);

        // Held NONSEQ to 0x800, no grant for 3 cycles after capture.
        tick();
        master(1'b1, 32'h800, 2'b10, 1'b0, 1'b1);
        decoder(1'b0, 1'b1, 2'b00);
        #1;
        chk("h_cap_addr", 64'(bus.addr_in), 64'h800);
        chk("h_cap_readyout", 64'(bus.HREADYOUTS), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            master(1'b1, 32'hDEAD_0000, 2'b11, 1'b1, 1'b1);
            decoder(i == 3, 1'b1, 2'b01);
            #1;
            chk("h_pend_readyout", 64'(bus.HREADYOUTS), 64'd0);
            chk("h_pend_resp", 64'(bus.HRESPS), 64'd0);
            chk("h_pend_addr", 64'(bus.addr_in), 64'h800);
            chk("h_pend_trans", 64'(bus.trans_in), 64'd2);
            chk("h_pend_write", 64'(bus.write_in), 64'd0);
            chk("h_pend_sel", 64'(bus.sel_in), 64'd1);
            chk("h_pend_ready_in", 64'(bus.ready_in), 64'd1);
        end
        tick();
        master(1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
        decoder(1'b1, 1'b1, 2'b00);
        #1;
        chk("h_data_readyout", 64'(bus.HREADYOUTS), 64'd1);
        chk("h_hold_cnt", 64'(hold_cnt), CNT_EN ? 64'd3 : 64'd0);

        // Held NONSEQ to 0xC00 then SEQ 0xC04 once granted.
        tick();
        master(1'b1, 32'hC00, 2'b10, 1'b1, 1'b1);
        decoder(1'b0, 1'b1, 2'b00);
        tick();
        bus.HREADYS = 1'b0;
        #1;
        chk("b_pend_addr", 64'(bus.addr_in), 64'hC00);
        chk("b_pend_readyout", 64'(bus.HREADYOUTS), 64'd0);
        tick();
        decoder(1'b1, 1'b1, 2'b00);
        #1;
        chk("b_grant_readyout", 64'(bus.HREADYOUTS), 64'd0);
        tick();
        master(1'b1, 32'hC04, 2'b11, 1'b1, 1'b1);
        decoder(1'b1, 1'b1, 2'b00);
        #1;
        chk("b_seq_addr", 64'(bus.addr_in), 64'hC04);
        chk("b_seq_trans", 64'(bus.trans_in), 64'd3);
        chk("b_d0_readyout", 64'(bus.HREADYOUTS), 64'd1);
        tick();
        master(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
        decoder(1'b1, 1'b0, 2'b00);
        #1;
        chk("b_d1_wait", 64'(bus.HREADYOUTS), 64'd0);
        tick();
        decoder(1'b1, 1'b1, 2'b00);
        bus.HREADYS = 1'b1;
        #1;
        chk("b_d1_done", 64'(bus.HREADYOUTS), 64'd1);

        // Two-cycle ERROR with a capture in the second cycle, then reset in PEND cycle 2.
        tick();
        master(1'b1, 32'h1000, 2'b10, 1'b0, 1'b1);
        decoder(1'b1, 1'b1, 2'b00);
        tick();
        master(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
        decoder(1'b1, 1'b0, 2'b01);
        #1;
        chk("e1_resp", 64'(bus.HRESPS), 64'd1);
        chk("e1_readyout", 64'(bus.HREADYOUTS), 64'd0);
        tick();
        master(1'b1, 32'h1400, 2'b10, 1'b1, 1'b1);
        decoder(1'b0, 1'b1, 2'b01);
        #1;
        chk("e2_resp", 64'(bus.HRESPS), 64'd1);
        chk("e2_readyout", 64'(bus.HREADYOUTS), 64'd1);
        tick();
        decoder(1'b0, 1'b1, 2'b00);
        #1;
        chk("e_cap_addr", 64'(bus.addr_in), 64'h1400);
        chk("e_cap_readyout", 64'(bus.HREADYOUTS), 64'd0);
        tick();
        HRESET = 1'b1;
        #1;
        chk("r_pend_readyout", 64'(bus.HREADYOUTS), 64'd0);
        chk("r_pend_sel", 64'(bus.sel_in), 64'd1);
        chk("r_pend_cnt", 64'(hold_cnt), CNT_EN ? 64'd1 : 64'd0);
        tick();
        HRESET = 1'b0;
        master(1'b0, 32'h55, 2'b00, 1'b0, 1'b1);
        decoder(1'b1, 1'b1, 2'b00);
        #1;
        chk("r_readyout", 64'(bus.HREADYOUTS), 64'd1);
        chk("r_resp", 64'(bus.HRESPS), 64'd0);
        chk("r_sel", 64'(bus.sel_in), 64'd0);
        chk("r_addr_pass", 64'(bus.addr_in), 64'h55);
        chk("r_hold_cnt", 64'(hold_cnt), 64'd0);
        chk("r_hold_reg", {19'b0, dut.hold_q}, 64'd0);

        // BUSY is never captured even without a grant.
        tick();
        master(1'b1, 32'h3000, 2'b01, 1'b0, 1'b1);
        decoder(1'b0, 1'b1, 2'b00);
        tick();
        master(1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
        #1;
        chk("busy_no_pend", 64'(bus.sel_in), 64'd0);
        chk("busy_readyout", 64'(bus.HREADYOUTS), 64'd1);

`ifdef RSP_S2_DMA_AHBIC_HOLD_CNT_EN
        // Long hold saturates the counter.
        tick();
        master(1'b1, 32'h2000, 2'b10, 1'b0, 1'b1);
        decoder(1'b0, 1'b1, 2'b00);
        tick();
        repeat (10) tick();
        chk("sat_cnt_10", 64'(hold_cnt), 64'd10);
        repeat (290) tick();
        chk("sat_cnt_pend", 64'(hold_cnt), 64'd255);
        decoder(1'b1, 1'b1, 2'b00);
        tick();
        master(1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
        tick();
        tick();
        chk("sat_cnt_idle", 64'(hold_cnt), 64'd255);
        chk("sat_idle_sel", 64'(bus.sel_in), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
